// File: rtl/stage_memory.sv
`default_nettype none
// ============================================================================
// stage_memory : MEM stage - sequences scalar/vector loads and stores over a
//                32-bit req/ack data bus and owns the MEM/WB register.
// Revision     : 1.0
// ============================================================================
module stage_memory #(
  parameter int LANES      = 4,
  parameter int WORD_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_clear,
  input  logic [31:0]           mem_instr,
  input  logic                  mem_reg_write,
  input  logic                  mem_mem_write,
  input  logic                  mem_mem_read,
  input  logic [1:0]            mem_result_src,
  input  logic                  mem_vector_op,
  input  logic [32*LANES-1:0]   mem_alu_result,
  input  logic [32*LANES-1:0]   mem_write_data,
  input  logic [31:0]           mem_pc_plus_4,
  input  logic [32*LANES-1:0]   mem_imm_ext,
  input  logic [4:0]            mem_rd,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [31:0]           dmem_addr,
  output logic [31:0]           dmem_wdata,
  input  logic [31:0]           dmem_rdata,
  input  logic                  dmem_ack,
  output logic                  mem_stall,
  output logic [31:0]           wb_instr,
  output logic                  wb_reg_write,
  output logic [1:0]            wb_result_src,
  output logic                  wb_vector_op,
  output logic [32*LANES-1:0]   wb_alu_result,
  output logic [32*LANES-1:0]   wb_read_data,
  output logic [31:0]           wb_pc_plus_4,
  output logic [32*LANES-1:0]   wb_imm_ext,
  output logic [4:0]            wb_rd
);

  localparam int BEAT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [BEAT_W-1:0] LAST_VEC_BEAT = BEAT_W'(LANES - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [32*LANES-1:0]   buf_q, buf_d;

  logic                  access;
  logic                  read_only;
  logic [BEAT_W-1:0]     cur_beat;
  logic                  last_beat;
  logic                  beat_done;
  logic                  done;
  logic [32*LANES-1:0]   rdata_asm;

  logic [31:0]           wb_instr_q, wb_instr_d;
  logic                  wb_reg_write_q, wb_reg_write_d;
  logic [1:0]            wb_result_src_q, wb_result_src_d;
  logic                  wb_vector_op_q, wb_vector_op_d;
  logic [32*LANES-1:0]   wb_alu_result_q, wb_alu_result_d;
  logic [32*LANES-1:0]   wb_read_data_q, wb_read_data_d;
  logic [31:0]           wb_pc_plus_4_q, wb_pc_plus_4_d;
  logic [32*LANES-1:0]   wb_imm_ext_q, wb_imm_ext_d;
  logic [4:0]            wb_rd_q, wb_rd_d;

  // A new access issues from IDLE in the same cycle, so IDLE always means beat 0.
  always_comb begin
    access    = mem_mem_read | mem_mem_write;
    read_only = mem_mem_read & ~mem_mem_write;
    cur_beat  = (state_q == IDLE) ? '0 : beat_q;
    last_beat = mem_vector_op ? (cur_beat == LAST_VEC_BEAT) : (cur_beat == '0);
    beat_done = access & dmem_ack;
    done      = beat_done & last_beat;

    dmem_req   = access;
    dmem_we    = mem_mem_write;
    dmem_addr  = mem_alu_result[31:0] + 32'(cur_beat) * 32'(WORD_BYTES);
    dmem_wdata = mem_write_data[32*cur_beat +: 32];
    mem_stall  = access & ~done;

    rdata_asm = '0;
    if (read_only) begin
      if (mem_vector_op) begin
        rdata_asm = buf_q;
        rdata_asm[32*(LANES-1) +: 32] = dmem_rdata;
      end else begin
        rdata_asm[31:0] = dmem_rdata;
      end
    end

    state_d = state_q;
    beat_d  = beat_q;
    buf_d   = buf_q;
    if (beat_done && read_only) begin
      buf_d[32*cur_beat +: 32] = dmem_rdata;
    end
    if (done) begin
      state_d = IDLE;
      beat_d  = '0;
    end else if (beat_done) begin
      state_d = ACCESS;
      beat_d  = cur_beat + 1'b1;
    end else if (access) begin
      state_d = ACCESS;
      beat_d  = cur_beat;
    end else begin
      state_d = IDLE;
      beat_d  = '0;
    end
  end

  // Stalled cycles load a bubble so a multi-cycle access reaches WB exactly once.
  always_comb begin
    wb_instr_d      = wb_instr_q;
    wb_reg_write_d  = 1'b0;
    wb_result_src_d = '0;
    wb_vector_op_d  = 1'b0;
    wb_alu_result_d = '0;
    wb_read_data_d  = '0;
    wb_pc_plus_4_d  = '0;
    wb_imm_ext_d    = '0;
    wb_rd_d         = '0;
    if (wb_clear) begin
      wb_instr_d = '0;
    end else if (!mem_stall) begin
      wb_instr_d      = mem_instr;
      wb_reg_write_d  = mem_reg_write;
      wb_result_src_d = mem_result_src;
      wb_vector_op_d  = mem_vector_op;
      wb_alu_result_d = mem_alu_result;
      wb_read_data_d  = rdata_asm;
      wb_pc_plus_4_d  = mem_pc_plus_4;
      wb_imm_ext_d    = mem_imm_ext;
      wb_rd_d         = mem_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      beat_q          <= '0;
      buf_q           <= '0;
      wb_instr_q      <= '0;
      wb_reg_write_q  <= 1'b0;
      wb_result_src_q <= '0;
      wb_vector_op_q  <= 1'b0;
      wb_alu_result_q <= '0;
      wb_read_data_q  <= '0;
      wb_pc_plus_4_q  <= '0;
      wb_imm_ext_q    <= '0;
      wb_rd_q         <= '0;
    end else begin
      state_q         <= state_d;
      beat_q          <= beat_d;
      buf_q           <= buf_d;
      wb_instr_q      <= wb_instr_d;
      wb_reg_write_q  <= wb_reg_write_d;
      wb_result_src_q <= wb_result_src_d;
      wb_vector_op_q  <= wb_vector_op_d;
      wb_alu_result_q <= wb_alu_result_d;
      wb_read_data_q  <= wb_read_data_d;
      wb_pc_plus_4_q  <= wb_pc_plus_4_d;
      wb_imm_ext_q    <= wb_imm_ext_d;
      wb_rd_q         <= wb_rd_d;
    end
  end

  assign wb_instr      = wb_instr_q;
  assign wb_reg_write  = wb_reg_write_q;
  assign wb_result_src = wb_result_src_q;
  assign wb_vector_op  = wb_vector_op_q;
  assign wb_alu_result = wb_alu_result_q;
  assign wb_read_data  = wb_read_data_q;
  assign wb_pc_plus_4  = wb_pc_plus_4_q;
  assign wb_imm_ext    = wb_imm_ext_q;
  assign wb_rd         = wb_rd_q;

endmodule
`default_nettype wire
